// File: rtl/vx_ibuffer_sched.sv
// Per-warp instruction FIFOs feeding a round-robin issue stage with a registered output.
// Optional feature: define VX_IBUF_BYPASS_EN to let an enqueue to an idle buffer skip its queue.
module vx_ibuffer_sched #(
    parameter int  NUM_WARPS = 4,
    parameter int  DEPTH     = 4,
    parameter int  DATAW     = 64,
    localparam int WIDW      = $clog2(NUM_WARPS),
    localparam int CNTW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enq_valid,
    input  logic [WIDW-1:0]           enq_wid,
    input  logic [DATAW-1:0]          enq_data,
    output logic                      enq_ready,
    output logic                      deq_valid,
    output logic [WIDW-1:0]           deq_wid,
    output logic [DATAW-1:0]          deq_data,
    input  logic                      deq_ready,
    input  logic [NUM_WARPS-1:0]      stall_mask,
    input  logic                      flush_valid,
    input  logic [WIDW-1:0]           flush_wid,
    output logic [NUM_WARPS*CNTW-1:0] used,
    output logic [NUM_WARPS-1:0]      empty_mask,
    output logic [NUM_WARPS-1:0]      full_mask
);
    localparam int PTRW = $clog2(DEPTH);

    logic [DATAW-1:0] mem_q    [NUM_WARPS][DEPTH];
    logic [PTRW-1:0]  rd_ptr_q [NUM_WARPS];
    logic [PTRW-1:0]  rd_ptr_d [NUM_WARPS];
    logic [PTRW-1:0]  wr_ptr_q [NUM_WARPS];
    logic [PTRW-1:0]  wr_ptr_d [NUM_WARPS];
    logic [CNTW-1:0]  used_q   [NUM_WARPS];
    logic [CNTW-1:0]  used_d   [NUM_WARPS];

    logic             deq_valid_q, deq_valid_d;
    logic [WIDW-1:0]  deq_wid_q, deq_wid_d;
    logic [DATAW-1:0] deq_data_q, deq_data_d;
    logic [WIDW-1:0]  rr_ptr_q, rr_ptr_d;

    logic [NUM_WARPS-1:0] flush_hit, eligible, push, pop;
    logic                 load, enq_fire, any_elig, bypass;
    logic [WIDW-1:0]      grant;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            flush_hit[w]            = flush_valid && (flush_wid == WIDW'(w));
            empty_mask[w]           = (used_q[w] == '0);
            full_mask[w]            = (used_q[w] == CNTW'(DEPTH));
            used[w*CNTW +: CNTW]    = used_q[w];
            eligible[w]             = !empty_mask[w] && !stall_mask[w] && !flush_hit[w];
        end
    end

    assign enq_ready = !full_mask[enq_wid] && !flush_hit[enq_wid];
    assign enq_fire  = enq_valid && enq_ready;
    assign load      = !deq_valid_q || deq_ready;

    // Search starts one past the last granted warp so every eligible warp gets a turn.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        any_elig = 1'b0;
        grant    = rr_ptr_q;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            if (!any_elig && eligible[(int'(rr_ptr_q) + i) % NUM_WARPS]) begin
                any_elig = 1'b1;
                grant    = WIDW'((int'(rr_ptr_q) + i) % NUM_WARPS);
            end
        end
    end

`ifdef VX_IBUF_BYPASS_EN
    assign bypass = load && !any_elig && enq_fire && empty_mask[enq_wid] && !stall_mask[enq_wid];
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            push[w]     = enq_fire && !bypass && (enq_wid == WIDW'(w));
            pop[w]      = load && any_elig && (grant == WIDW'(w));
            rd_ptr_d[w] = rd_ptr_q[w];
            wr_ptr_d[w] = wr_ptr_q[w];
            used_d[w]   = used_q[w];
            if (flush_hit[w]) begin
                rd_ptr_d[w] = '0;
                wr_ptr_d[w] = '0;
                used_d[w]   = '0;
            end else begin
                if (push[w]) wr_ptr_d[w] = ptr_inc(wr_ptr_q[w]);
                if (pop[w])  rd_ptr_d[w] = ptr_inc(rd_ptr_q[w]);
                used_d[w] = used_q[w] + CNTW'(push[w]) - CNTW'(pop[w]);
            end
        end
    end

    always_comb begin
        deq_valid_d = deq_valid_q;
        deq_wid_d   = deq_wid_q;
        deq_data_d  = deq_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            if (any_elig) begin
                deq_valid_d = 1'b1;
                deq_wid_d   = grant;
                deq_data_d  = mem_q[grant][rd_ptr_q[grant]];
                rr_ptr_d    = grant;
            end else if (bypass) begin
                deq_valid_d = 1'b1;
                deq_wid_d   = enq_wid;
                deq_data_d  = enq_data;
                rr_ptr_d    = enq_wid;
            end else begin
                deq_valid_d = 1'b0;
            end
        end else if (flush_valid && (flush_wid == deq_wid_q)) begin
            // A stalled output belonging to the flushed warp is discarded.
            deq_valid_d = 1'b0;
        end
    end

    // NOTE: the payload array has no reset; used_q gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (push[w]) mem_q[w][wr_ptr_q[w]] <= enq_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr_q[w] <= '0;
                wr_ptr_q[w] <= '0;
                used_q[w]   <= '0;
            end
            deq_valid_q <= 1'b0;
            deq_wid_q   <= '0;
            deq_data_q  <= '0;
            rr_ptr_q    <= WIDW'(NUM_WARPS - 1);
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr_q[w] <= rd_ptr_d[w];
                wr_ptr_q[w] <= wr_ptr_d[w];
                used_q[w]   <= used_d[w];
            end
            deq_valid_q <= deq_valid_d;
            deq_wid_q   <= deq_wid_d;
            deq_data_q  <= deq_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign deq_valid = deq_valid_q;
    assign deq_wid   = deq_wid_q;
    assign deq_data  = deq_data_q;

endmodule

// File: tb/tb_vx_ibuffer_sched.sv
// Self-checking bench for vx_ibuffer_sched: per-warp scoreboards checked at every output handshake,
// plus scenario tasks for reset, round-robin, full, stall, flush, latency and reset mid-operation.
module tb_vx_ibuffer_sched;
    localparam int NW   = 4;
    localparam int DW   = 64;
    localparam int WIDW = 2;
    localparam int CNTW = 3;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enq_valid;
    logic [WIDW-1:0]    enq_wid;
    logic [DW-1:0]      enq_data;
    logic               enq_ready;
    logic               deq_valid;
    logic [WIDW-1:0]    deq_wid;
    logic [DW-1:0]      deq_data;
    logic               deq_ready;
    logic [NW-1:0]      stall_mask;
    logic               flush_valid;
    logic [WIDW-1:0]    flush_wid;
    logic [NW*CNTW-1:0] used;
    logic [NW-1:0]      empty_mask;
    logic [NW-1:0]      full_mask;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] sb [NW][$];
    int            wid_log [$];
    logic [DW-1:0] exp_head;

    vx_ibuffer_sched #(.NUM_WARPS(NW), .DEPTH(4), .DATAW(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enq_valid  (enq_valid),
        .enq_wid    (enq_wid),
        .enq_data   (enq_data),
        .enq_ready  (enq_ready),
        .deq_valid  (deq_valid),
        .deq_wid    (deq_wid),
        .deq_data   (deq_data),
        .deq_ready  (deq_ready),
        .stall_mask (stall_mask),
        .flush_valid(flush_valid),
        .flush_wid  (flush_wid),
        .used       (used),
        .empty_mask (empty_mask),
        .full_mask  (full_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor on the falling edge: inputs and outputs are stable for the coming rising edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (deq_valid && deq_ready) begin
                checks++;
                if (sb[deq_wid].size() == 0) begin
                    failures++;
                    $display("FAIL deq_unexpected: got wid=%0d data=%h, expected no output", deq_wid, deq_data);
                end else begin
                    exp_head = sb[deq_wid].pop_front();
                    if (deq_data !== exp_head) begin
                        failures++;
                        $display("FAIL deq_order wid=%0d: got %h expected %h", deq_wid, deq_data, exp_head);
                    end
                end
                wid_log.push_back(int'(deq_wid));
            end
            if (flush_valid) sb[flush_wid].delete();
            if (enq_valid && enq_ready) sb[enq_wid].push_back(enq_data);
        end
    end

    function automatic logic [CNTW-1:0] used_of(input int w);
        return used[w*CNTW +: CNTW];
    endfunction

    function automatic int sb_total();
        int s = 0;
        for (int w = 0; w < NW; w++) s += sb[w].size();
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [WIDW-1:0] w, input logic [DW-1:0] d);
        enq_valid = 1'b1;
        enq_wid   = w;
        enq_data  = d;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        deq_ready = 1'b1;
        while ((deq_valid || sb_total() != 0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL %s_drain: got %0d pending after timeout, expected 0", name, sb_total());
        end
        checks++;
        if (empty_mask !== 4'hF) begin
            failures++;
            $display("FAIL %s_drain_empty: got %b expected 1111", name, empty_mask);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enq_valid = 1'b1; enq_wid = '0; enq_data = 64'hDEAD;
        repeat (3) tick();
        reset_n = 1'b1;
        #1;
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_deq_valid: got %b expected 0", deq_valid); end
        checks++; if (deq_wid !== 2'd0) begin failures++; $display("FAIL reset_deq_wid: got %0d expected 0", deq_wid); end
        checks++; if (deq_data !== 64'd0) begin failures++; $display("FAIL reset_deq_data: got %h expected 0", deq_data); end
        checks++; if (empty_mask !== 4'b1111) begin failures++; $display("FAIL reset_empty_mask: got %b expected 1111", empty_mask); end
        checks++; if (full_mask !== 4'b0000) begin failures++; $display("FAIL reset_full_mask: got %b expected 0000", full_mask); end
        checks++; if (used !== '0) begin failures++; $display("FAIL reset_used: got %h expected 0", used); end
        enq_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_w [6] = '{0, 1, 3, 0, 1, 3};
        stall_mask = 4'hF; deq_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            enq(2'd0, 64'h0100 + 64'(r));
            enq(2'd1, 64'h1100 + 64'(r));
            enq(2'd3, 64'h3100 + 64'(r));
        end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL rr_stalled_valid: got %b expected 0", deq_valid); end
        wid_log.delete();
        stall_mask = 4'h0;
        drain("rr");
        checks++;
        if (wid_log.size() != 6) begin
            failures++;
            $display("FAIL rr_count: got %0d expected 6", wid_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wid_log[i] != exp_w[i]) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", i, wid_log[i], exp_w[i]);
                end
            end
        end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL rr_idle_valid: got %b expected 0", deq_valid); end
    endtask

    task automatic test_fill();
        deq_ready = 1'b0; stall_mask = 4'h0;
        for (int i = 0; i < 5; i++) enq(2'd2, 64'h2A00 + 64'(i));
        checks++; if (full_mask !== 4'b0100) begin failures++; $display("FAIL fill_full_mask: got %b expected 0100", full_mask); end
        checks++; if (used_of(2) !== 3'd4) begin failures++; $display("FAIL fill_used2: got %0d expected 4", used_of(2)); end
        checks++; if (deq_data !== 64'h2A00) begin failures++; $display("FAIL fill_head: got %h expected 2a00", deq_data); end
        enq_wid = 2'd2; #1;
        checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_w2: got %b expected 0", enq_ready); end
        enq_wid = 2'd0; #1;
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_w0: got %b expected 1", enq_ready); end
        tick();
        checks++; if (deq_valid !== 1'b1 || deq_data !== 64'h2A00) begin failures++; $display("FAIL fill_hold: got v=%b d=%h expected v=1 d=2a00", deq_valid, deq_data); end
        // Full queue must reject even while its head is being popped.
        enq_valid = 1'b1; enq_wid = 2'd2; enq_data = 64'hBAD2; deq_ready = 1'b1; #1;
        checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL fill_no_passthru: got %b expected 0", enq_ready); end
        tick();
        enq_valid = 1'b0;
        drain("fill");
    endtask

    task automatic test_stall();
        stall_mask = 4'hF; deq_ready = 1'b1;
        enq(2'd0, 64'h0500); enq(2'd0, 64'h0501);
        enq(2'd1, 64'h1500); enq(2'd1, 64'h1501);
        wid_log.delete();
        stall_mask = 4'b0010;
        repeat (4) tick();
        checks++; if (wid_log.size() != 2) begin failures++; $display("FAIL stall_count: got %0d expected 2", wid_log.size()); end
        checks++; if (wid_log.size() >= 2 && (wid_log[0] != 0 || wid_log[1] != 0)) begin failures++; $display("FAIL stall_wids: got %0d,%0d expected 0,0", wid_log[0], wid_log[1]); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL stall_valid: got %b expected 0", deq_valid); end
        checks++; if (used_of(1) !== 3'd2) begin failures++; $display("FAIL stall_used1: got %0d expected 2", used_of(1)); end
        stall_mask = 4'h0;
        tick();
        checks++; if (deq_valid !== 1'b1 || deq_wid !== 2'd1) begin failures++; $display("FAIL stall_resume: got v=%b wid=%0d expected v=1 wid=1", deq_valid, deq_wid); end
        drain("stall");
    endtask

    task automatic test_flush();
        deq_ready = 1'b0; stall_mask = 4'h0;
        for (int i = 0; i < 4; i++) enq(2'd1, 64'h1F00 + 64'(i));
        checks++; if (deq_valid !== 1'b1 || deq_wid !== 2'd1) begin failures++; $display("FAIL flush_pre_out: got v=%b wid=%0d expected v=1 wid=1", deq_valid, deq_wid); end
        checks++; if (used_of(1) !== 3'd3) begin failures++; $display("FAIL flush_pre_used1: got %0d expected 3", used_of(1)); end
        flush_valid = 1'b1; flush_wid = 2'd1;
        enq_valid = 1'b1; enq_wid = 2'd1; enq_data = 64'hBAD1; #1;
        checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL flush_enq_ready: got %b expected 0", enq_ready); end
        tick();
        flush_valid = 1'b0; enq_valid = 1'b0;
        checks++; if (used_of(1) !== 3'd0) begin failures++; $display("FAIL flush_used1: got %0d expected 0", used_of(1)); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL flush_deq_valid: got %b expected 0", deq_valid); end
        checks++; if (empty_mask !== 4'hF) begin failures++; $display("FAIL flush_empty: got %b expected 1111", empty_mask); end
        enq(2'd1, 64'h1F10);
        drain("flush");
    endtask

    task automatic test_latency();
        logic exp_v1;
        logic [CNTW-1:0] exp_u1;
`ifdef VX_IBUF_BYPASS_EN
        exp_v1 = 1'b1; exp_u1 = 3'd0;
`else
        exp_v1 = 1'b0; exp_u1 = 3'd1;
`endif
        deq_ready = 1'b0; stall_mask = 4'h0;
        enq(2'd2, 64'h3300);
        checks++; if (deq_valid !== exp_v1) begin failures++; $display("FAIL lat_edge_n_valid: got %b expected %b", deq_valid, exp_v1); end
        checks++; if (used_of(2) !== exp_u1) begin failures++; $display("FAIL lat_edge_n_used2: got %0d expected %0d", used_of(2), exp_u1); end
        tick();
        checks++; if (deq_valid !== 1'b1 || deq_wid !== 2'd2 || deq_data !== 64'h3300) begin failures++; $display("FAIL lat_edge_n1_out: got v=%b wid=%0d d=%h expected v=1 wid=2 d=3300", deq_valid, deq_wid, deq_data); end
        checks++; if (used_of(2) !== 3'd0) begin failures++; $display("FAIL lat_edge_n1_used2: got %0d expected 0", used_of(2)); end
        drain("latency");
    endtask

    task automatic test_back_to_back();
        stall_mask = 4'hF; deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) enq(2'd3, 64'h3B00 + 64'(i));
        stall_mask = 4'h0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (deq_valid !== 1'b1 || deq_wid !== 2'd3) begin
                failures++;
                $display("FAIL b2b_cycle%0d: got v=%b wid=%0d expected v=1 wid=3", k, deq_valid, deq_wid);
            end
        end
        tick();
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid: got %b expected 0", deq_valid); end
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        deq_ready = 1'b0; stall_mask = 4'h0;
        enq(2'd0, 64'h0700); enq(2'd0, 64'h0701); enq(2'd2, 64'h2700);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        for (int w = 0; w < NW; w++) sb[w].delete();
        #1;
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL rstmid_deq_valid: got %b expected 0", deq_valid); end
        checks++; if (used !== '0) begin failures++; $display("FAIL rstmid_used: got %h expected 0", used); end
        checks++; if (empty_mask !== 4'hF) begin failures++; $display("FAIL rstmid_empty: got %b expected 1111", empty_mask); end
        tick();
        reset_n = 1'b1;
        enq(2'd1, 64'h1700);
        drain("rstmid");
    endtask

    initial begin
        reset_n = 1'b0; enq_valid = 1'b0; enq_wid = '0; enq_data = '0;
        deq_ready = 1'b0; stall_mask = '0; flush_valid = 1'b0; flush_wid = '0;
        test_reset();
        test_round_robin();
        test_fill();
        test_stall();
        test_flush();
        test_latency();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vx_ibuffer_sched.md
# vx_ibuffer_sched

Per-warp instruction buffer with integrated round-robin issue scheduler, sitting between decode and the scoreboard/issue stage. Holds up to DEPTH decoded instructions per warp in independent FIFOs, selects one eligible warp per cycle into a registered output stage, and supports per-warp flush and a scoreboard stall mask. It generalises warp count, depth and payload width.

## Interface
- NUM_WARPS, 4, number of warp queues (≥2)
- DEPTH, 4, entries per warp queue (≥2)
- DATAW, 64, instruction payload width
- (local) WIDW = $clog2(NUM_WARPS); CNTW = $clog2(DEPTH+1)
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enq_valid  in  1  decode offers instruction
- enq_wid  in  WIDW  target warp
- enq_data  in  DATAW  instruction payload
- enq_ready  out  1  combinational accept
- deq_valid  out  1  registered output valid
- deq_wid  out  WIDW  warp of output instruction
- deq_data  out  DATAW  output payload
- deq_ready  in  1  issue stage accepts
- stall_mask  in  NUM_WARPS  bit set = warp ineligible for selection this cycle
- flush_valid  in  1  discard all state for flush_wid
- flush_wid  in  WIDW  warp to flush
- used  out  NUM_WARPS*CNTW  per-warp queue occupancy (excludes output register)
- empty_mask  out  NUM_WARPS  used==0 per warp
- full_mask  out  NUM_WARPS  used==DEPTH per warp

## Operation
- enq_ready = !full_mask[enq_wid] && !(flush_valid && flush_wid==enq_wid); enq fires on enq_valid&&enq_ready.
- Full queue rejects even if the same warp is popped that cycle (no pass-through).
- Per-warp FIFO order strictly preserved end to end.
- Load condition: load = !deq_valid || deq_ready.
- Eligible[w] = !empty_mask[w] && !stall_mask[w] && !(flush_valid && flush_wid==w); same-cycle enqueues are not eligible.
- On load with any eligible warp: round-robin grant starting at rr_ptr+1 (mod NUM_WARPS); head of granted queue popped into output register; rr_ptr <= granted warp.
- On load with none eligible: deq_valid <= 0.
- Without load: output register holds (deq_valid/deq_wid/deq_data stable while deq_valid && !deq_ready).
- used[w] <= used[w] + push - pop; flush sets used[w] <= 0 and drops any same-cycle push (enq_ready low).
- Flush of warp equal to deq_wid with deq_valid: a handshake completing that cycle counts as delivered; output register is invalidated (deq_valid <= 0) unless refilled from another warp the same edge.
- Reset: deq_valid 0, deq_wid 0, deq_data 0, all used 0, empty_mask all 1, full_mask 0, rr_ptr NUM_WARPS-1 (warp 0 first). Reset mid-operation discards all queued and output instructions immediately.

## Timing
- enq fire at edge N → used/empty_mask updated after edge N.
- Earliest deq_valid for that instruction: after edge N+1 (2-cycle latency) without bypass.
- Selection, pop and output load happen on the same edge; one instruction issued per cycle max; sustained 1/cycle with ≥1 eligible warp.
- empty_mask/full_mask/used are registered-state-derived, no combinational path from enq_valid.

## Configuration
- VX_IBUF_BYPASS_EN defined: when load holds, no warp is eligible, and an enq fires to a warp with empty queue, not stalled, not flushed, the payload goes directly into the output register (deq_valid after edge N, 1-cycle latency); queue and used unchanged; rr_ptr <= enq_wid.
- Undefined: all instructions pass through the queue; minimum latency 2 cycles.

## Test plan
- Reset with enq_valid=1 held: after reset_n release, enq_ready=1, deq_valid=0, empty_mask=4'b1111, used all 0.
- Fill warp 2 with 4 entries (DEPTH=4), deq_ready=0: full_mask=4'b0100, enq_ready=0 for wid 2, 1 for wid 0; data pops out in order A,B,C,D once deq_ready=1.
- Warps 0,1,3 each hold 2 entries, deq_ready=1: deq_wid sequence 0,1,3,0,1,3 then deq_valid=0.
- stall_mask=4'b0010 with warps 0,1 loaded: only warp 0 issues; clearing bit resumes warp 1 next cycle.
- flush_wid=1 while warp 1 has 3 entries and occupies output register with deq_ready=0: next cycle used[1]=0, deq_valid=0 (or other warp's instruction).
- Single enqueue to idle buffer: deq_valid rises 2 cycles after enq edge; with VX_IBUF_BYPASS_EN, 1 cycle, used stays 0.
